pipeline_latch_buf: RTL and testbench

- Parametrised, elastic successor to the fixed per-stage pipeline latches (fetch/decode/execute latches).
- Holds a WIDTH-bit packed control/data bundle in a DEPTH-entry circular buffer.
- Uses valid/ready handshakes on both sides, with synchronous flush.
- Outputs a programmable bubble word when empty, so downstream stages see NOP control (regWEN/dWEN/dREN/halt = 0) without extra gating.

---
 rtl/pipeline_latch_buf.sv | 81 ++++++++
 tb/tb_pipeline_latch_buf.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_latch_buf.sv
// Elastic pipeline latch: DEPTH-entry circular buffer with valid/ready
// handshakes on both sides, synchronous flush and a bubble word when empty.
module pipeline_latch_buf #(
    parameter int unsigned      WIDTH  = 64,
    parameter int unsigned      DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_wr_nxt;
    logic [PW-1:0]    w_rd_nxt;

    // in_ready looks only at registered occupancy, never at out_ready
    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : BUBBLE;
    assign count     = r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // explicit wrap so non-power-of-two depths stay in range
    assign w_wr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // storage needs no reset: it is masked by BUBBLE while empty
    always_ff @(posedge CLK) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    a_count_bound: assert property (
        @(posedge CLK) disable iff (RST) r_count <= CW'(DEPTH)
    );

endmodule

// File: tb/tb_pipeline_latch_buf.sv
// Directed bench for pipeline_latch_buf: DEPTH=2, DEPTH=3 and DEPTH=1
// builds sharing one clock and reset, each scenario in its own task.
module tb_pipeline_latch_buf;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 CLK = ~CLK;

    logic       d2_fl, d2_iv, d2_ir, d2_ov, d2_or;
    logic [7:0] d2_id, d2_od;
    logic [1:0] d2_cnt;

    logic       d3_fl, d3_iv, d3_ir, d3_ov, d3_or;
    logic [7:0] d3_id, d3_od;
    logic [1:0] d3_cnt;

    logic       d1_fl, d1_iv, d1_ir, d1_ov, d1_or;
    logic [7:0] d1_id, d1_od;
    logic [0:0] d1_cnt;

    logic [11:0] exp_v;
    logic [11:0] got_v;
    logic [10:0] exp1;
    logic [10:0] got1;

    pipeline_latch_buf #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'hA5)) u_d2 (
        .CLK(CLK), .RST(RST), .flush(d2_fl),
        .in_valid(d2_iv), .in_ready(d2_ir), .in_data(d2_id),
        .out_valid(d2_ov), .out_ready(d2_or), .out_data(d2_od),
        .count(d2_cnt)
    );

    pipeline_latch_buf #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'hA5)) u_d3 (
        .CLK(CLK), .RST(RST), .flush(d3_fl),
        .in_valid(d3_iv), .in_ready(d3_ir), .in_data(d3_id),
        .out_valid(d3_ov), .out_ready(d3_or), .out_data(d3_od),
        .count(d3_cnt)
    );

    pipeline_latch_buf #(.WIDTH(8), .DEPTH(1), .BUBBLE(8'hA5)) u_d1 (
        .CLK(CLK), .RST(RST), .flush(d1_fl),
        .in_valid(d1_iv), .in_ready(d1_ir), .in_data(d1_id),
        .out_valid(d1_ov), .out_ready(d1_or), .out_data(d1_od),
        .count(d1_cnt)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        exp_v = {1'b0, 8'hA5, 2'd0, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_hold_d2 got=%h exp=%h", got_v, exp_v);
        end
        got_v = {d3_ov, d3_od, d3_cnt, d3_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_hold_d3 got=%h exp=%h", got_v, exp_v);
        end
        exp1 = {1'b0, 8'hA5, 1'b0, 1'b1};
        got1 = {d1_ov, d1_od, d1_cnt, d1_ir};
        checks++;
        if (got1 !== exp1) begin
            errors++;
            $display("FAIL reset_hold_d1 got=%h exp=%h", got1, exp1);
        end
        RST = 1'b0;
        d2_iv = 1'b1;
        d2_id = 8'hEE;
        tick();
        d2_iv = 1'b0;
        exp_v = {1'b1, 8'hEE, 2'd1, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_prefill got=%h exp=%h", got_v, exp_v);
        end
        #3;
        RST = 1'b1;
        d2_iv = 1'b1;
        d2_id = 8'hDD;
        #1;
        exp_v = {1'b0, 8'hA5, 2'd0, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", got_v, exp_v);
        end
        #2;
        d2_iv = 1'b0;
        RST = 1'b0;
        tick();
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_streaming;
        d2_or = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d2_iv = 1'b1;
            d2_id = 8'(i);
            tick();
            exp_v = {1'b1, 8'(i), 2'd1, 1'b1};
            got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL stream_%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        d2_iv = 1'b0;
        tick();
        exp_v = {1'b0, 8'hA5, 2'd0, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL stream_drain got=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_backpressure;
        d2_or = 1'b0;
        d2_iv = 1'b1;
        d2_id = 8'h11;
        tick();
        d2_id = 8'h22;
        tick();
        exp_v = {1'b1, 8'h11, 2'd2, 1'b0};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL bp_full got=%h exp=%h", got_v, exp_v);
        end
        d2_id = 8'h33;
        tick();
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL bp_hold got=%h exp=%h", got_v, exp_v);
        end
        d2_or = 1'b1;
        #1;
        checks++;
        if (d2_ir !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_comb_ready got=%b exp=0", d2_ir);
        end
        tick();
        d2_or = 1'b0;
        exp_v = {1'b1, 8'h22, 2'd1, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL bp_pop_one got=%h exp=%h", got_v, exp_v);
        end
        tick();
        d2_iv = 1'b0;
        d2_or = 1'b1;
        exp_v = {1'b1, 8'h22, 2'd2, 1'b0};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL bp_refill got=%h exp=%h", got_v, exp_v);
        end
        tick();
        exp_v = {1'b1, 8'h33, 2'd1, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL bp_drain33 got=%h exp=%h", got_v, exp_v);
        end
        tick();
        d2_or = 1'b0;
    endtask

    task automatic test_wrap;
        d3_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d3_iv = 1'b1;
            d3_id = 8'h50 + 8'(i);
            tick();
            exp_v = {1'b1, 8'h50 + 8'(i), 2'd1, 1'b1};
            got_v = {d3_ov, d3_od, d3_cnt, d3_ir};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL wrap_pair_%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        d3_iv = 1'b0;
        tick();
        d3_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d3_iv = 1'b1;
            d3_id = 8'h60 + 8'(i);
            tick();
        end
        d3_iv = 1'b0;
        exp_v = {1'b1, 8'h60, 2'd3, 1'b0};
        got_v = {d3_ov, d3_od, d3_cnt, d3_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL wrap_full got=%h exp=%h", got_v, exp_v);
        end
        d3_or = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i < 3) exp_v = {1'b1, 8'h60 + 8'(i), 2'(3 - i), 1'b1};
            else       exp_v = {1'b0, 8'hA5, 2'd0, 1'b1};
            got_v = {d3_ov, d3_od, d3_cnt, d3_ir};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL wrap_drain_%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        d3_or = 1'b0;
    endtask

    task automatic test_flush;
        d2_or = 1'b0;
        d2_iv = 1'b1;
        d2_id = 8'h40;
        tick();
        d2_id = 8'h41;
        tick();
        d2_fl = 1'b1;
        d2_id = 8'h42;
        d2_or = 1'b1;
        #1;
        exp_v = {1'b1, 8'h40, 2'd2, 1'b0};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL flush_pop_head got=%h exp=%h", got_v, exp_v);
        end
        tick();
        d2_fl = 1'b0;
        exp_v = {1'b0, 8'hA5, 2'd0, 1'b1};
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL flush_empty got=%h exp=%h", got_v, exp_v);
        end
        d2_iv = 1'b0;
        tick();
        got_v = {d2_ov, d2_od, d2_cnt, d2_ir};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL flush_no42 got=%h exp=%h", got_v, exp_v);
        end
        d2_or = 1'b0;
    endtask

    task automatic test_depth1;
        d1_or = 1'b1;
        d1_iv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d1_id = 8'h71 + 8'(i);
            checks++;
            if (d1_ir !== 1'b1) begin
                errors++;
                $display("FAIL d1_ready_hi_%0d got=%b exp=1", i, d1_ir);
            end
            tick();
            exp1 = {1'b1, 8'h71 + 8'(i), 1'b1, 1'b0};
            got1 = {d1_ov, d1_od, d1_cnt, d1_ir};
            checks++;
            if (got1 !== exp1) begin
                errors++;
                $display("FAIL d1_emit_%0d got=%h exp=%h", i, got1, exp1);
            end
            tick();
            exp1 = {1'b0, 8'hA5, 1'b0, 1'b1};
            got1 = {d1_ov, d1_od, d1_cnt, d1_ir};
            checks++;
            if (got1 !== exp1) begin
                errors++;
                $display("FAIL d1_gap_%0d got=%h exp=%h", i, got1, exp1);
            end
        end
        d1_iv = 1'b0;
    endtask

    initial begin
        {d2_fl, d2_iv, d2_or} = '0;
        {d3_fl, d3_iv, d3_or} = '0;
        {d1_fl, d1_iv, d1_or} = '0;
        d2_id = '0;
        d3_id = '0;
        d1_id = '0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_flush();
        test_depth1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
